// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   owner_e   : identifies which requester issued a memory transaction
//   DEF_*     : default parameter values used by the arbiter and its FIFO
//   owner_req : returns the live request line belonging to a given owner
package mem_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_DEPTH      = 2;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // Request line of the requester named by owner.
    function automatic logic owner_req(input owner_e owner,
                                       input logic   instr_req,
                                       input logic   data_req);
        logic req;
        case (owner)
            OWN_DATA:  req = data_req;
            OWN_INSTR: req = instr_req;
            default:   req = 1'b0;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which requester owns each outstanding memory transaction.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   push, din  : append an owner id (ignored when full)
//   pop, dout  : drop the head entry (ignored when empty); dout is the head
//   full, empty, count : occupancy status
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  owner_e           din,
    output owner_e           dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_e             slots_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Pointers wrap at DEPTH rather than at a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign dout      = slots_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots_r[i] <= OWN_INSTR;
            end
        end else if (push_ok_s) begin
            slots_r[wr_ptr_r] <= din;
        end
    end

    // Head/tail pointers and occupancy; simultaneous push and pop keeps count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory req/gnt/rvalid port between fetch and load/store.
// Data wins by default; fetch is forced through after STARVE_MAX data grants
// while it waits. An ungranted decision is locked until granted. Up to DEPTH
// outstanding transactions are tracked so in-order responses reach their issuer.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   instr_*             : fetch request (read only), grant, response
//   data_*              : load/store request, grant, response
//   mem_*               : shared memory port
//   busy_out            : transactions outstanding
//   err_out             : sticky, response arrived with nothing outstanding
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_req_in,
    input  logic [ADDR_W-1:0]     instr_addr_in,
    output logic                  instr_gnt_out,
    output logic                  instr_rvalid_out,
    output logic [DATA_W-1:0]     instr_rdata_out,
    input  logic                  data_req_in,
    input  logic                  data_we_in,
    input  logic [DATA_W/8-1:0]   data_be_in,
    input  logic [ADDR_W-1:0]     data_addr_in,
    input  logic [DATA_W-1:0]     data_wdata_in,
    output logic                  data_gnt_out,
    output logic                  data_rvalid_out,
    output logic [DATA_W-1:0]     data_rdata_out,
    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic [DATA_W/8-1:0]   mem_be_out,
    output logic [ADDR_W-1:0]     mem_addr_out,
    output logic [DATA_W-1:0]     mem_wdata_out,
    input  logic                  mem_gnt_in,
    input  logic                  mem_rvalid_in,
    input  logic [DATA_W-1:0]     mem_rdata_in,
    output logic                  busy_out,
    output logic                  err_out
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              lock_valid_r;
    owner_e            lock_owner_r;
    logic [STV_W-1:0]  starve_r;
    logic              err_r;

    logic              lock_live_s;
    logic              sel_valid_s;
    owner_e            sel_owner_s;
    logic              grant_s;
    logic              head_valid_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    owner_e            fifo_head_s;
    logic [CNT_W-1:0]  fifo_count_s;

    owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grant_s),
        .pop   (mem_rvalid_in),
        .din   (sel_owner_s),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Owner selection; a lock whose requester has withdrawn no longer applies.
    // Held in reset, no owner is chosen so every output stays low.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_owner_s = OWN_DATA;
        lock_live_s = lock_valid_r && owner_req(lock_owner_r, instr_req_in, data_req_in);
        if (!reset || fifo_full_s) begin
            sel_valid_s = 1'b0;
        end else if (lock_live_s) begin
            sel_valid_s = 1'b1;
            sel_owner_s = lock_owner_r;
        end else if ((starve_r == STV_W'(STARVE_MAX)) && instr_req_in) begin
            sel_valid_s = 1'b1;
            sel_owner_s = OWN_INSTR;
        end else if (data_req_in) begin
            sel_valid_s = 1'b1;
            sel_owner_s = OWN_DATA;
        end else if (instr_req_in) begin
            sel_valid_s = 1'b1;
            sel_owner_s = OWN_INSTR;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Memory port payload from the selected owner; fetch is a full-word read.
    always_comb begin
        mem_req_out   = sel_valid_s;
        mem_we_out    = 1'b0;
        mem_be_out    = {BE_W{1'b0}};
        mem_addr_out  = {ADDR_W{1'b0}};
        mem_wdata_out = {DATA_W{1'b0}};
        if (sel_valid_s) begin
            case (sel_owner_s)
                OWN_DATA: begin
                    mem_we_out    = data_we_in;
                    mem_be_out    = data_be_in;
                    mem_addr_out  = data_addr_in;
                    mem_wdata_out = data_wdata_in;
                end
                OWN_INSTR: begin
                    mem_be_out    = {BE_W{1'b1}};
                    mem_addr_out  = instr_addr_in;
                end
                default: begin
                    mem_req_out   = 1'b0;
                end
            endcase
        end else begin
            mem_req_out = 1'b0;
        end
    end

    assign grant_s       = mem_gnt_in && sel_valid_s;
    assign instr_gnt_out = grant_s && (sel_owner_s == OWN_INSTR);
    assign data_gnt_out  = grant_s && (sel_owner_s == OWN_DATA);

    // Responses go only to the owner at the FIFO head.
    assign head_valid_s     = mem_rvalid_in && !fifo_empty_s;
    assign instr_rvalid_out = head_valid_s && (fifo_head_s == OWN_INSTR);
    assign data_rvalid_out  = head_valid_s && (fifo_head_s == OWN_DATA);
    assign instr_rdata_out  = mem_rdata_in;
    assign data_rdata_out   = mem_rdata_in;

    assign busy_out = (fifo_count_s != {CNT_W{1'b0}});
    assign err_out  = err_r;

    // Lock: capture an ungranted decision, release on grant or withdrawal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_valid_r <= 1'b0;
            lock_owner_r <= OWN_INSTR;
        end else if (sel_valid_s && !mem_gnt_in) begin
            lock_valid_r <= 1'b1;
            lock_owner_r <= sel_owner_s;
        end else if (grant_s) begin
            lock_valid_r <= 1'b0;
        end else if (lock_valid_r && !owner_req(lock_owner_r, instr_req_in, data_req_in)) begin
            lock_valid_r <= 1'b0;
        end
    end

    // Starvation count: data grants taken while fetch is waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_r <= {STV_W{1'b0}};
        end else if (!instr_req_in || instr_gnt_out) begin
            starve_r <= {STV_W{1'b0}};
        end else if (data_gnt_out && (starve_r != STV_W'(STARVE_MAX))) begin
            starve_r <= starve_r + STV_W'(1);
        end
    end

    // Sticky error on a response with nothing outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (mem_rvalid_in && fifo_empty_s) begin
            err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based
// reference model of the arbitration, lock, starvation and routing rules.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          instr_req_in = 1'b0;
    logic [AW-1:0] instr_addr_in = '0;
    logic          instr_gnt_out, instr_rvalid_out;
    logic [DW-1:0] instr_rdata_out;
    logic          data_req_in = 1'b0, data_we_in = 1'b0;
    logic [BW-1:0] data_be_in = '0;
    logic [AW-1:0] data_addr_in = '0;
    logic [DW-1:0] data_wdata_in = '0;
    logic          data_gnt_out, data_rvalid_out;
    logic [DW-1:0] data_rdata_out;
    logic          mem_req_out, mem_we_out;
    logic [BW-1:0] mem_be_out;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_wdata_out;
    logic          mem_gnt_in = 1'b0, mem_rvalid_in = 1'b0;
    logic [DW-1:0] mem_rdata_in = '0;
    logic          busy_out, err_out;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .instr_req_in(instr_req_in), .instr_addr_in(instr_addr_in),
        .instr_gnt_out(instr_gnt_out), .instr_rvalid_out(instr_rvalid_out),
        .instr_rdata_out(instr_rdata_out),
        .data_req_in(data_req_in), .data_we_in(data_we_in), .data_be_in(data_be_in),
        .data_addr_in(data_addr_in), .data_wdata_in(data_wdata_in),
        .data_gnt_out(data_gnt_out), .data_rvalid_out(data_rvalid_out),
        .data_rdata_out(data_rdata_out),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_be_out(mem_be_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
        .busy_out(busy_out), .err_out(err_out)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of issuers (0 = fetch, 1 = data), pending lock,
    // count of data grants while fetch waits, sticky error.
    bit oq[$];
    bit lock_v, lock_o, err_m;
    int starve;

    // Model grant decisions and DUT observations of the last step.
    bit            m_igt, m_dgt;
    logic          o_igt, o_dgt, o_irv, o_drv, o_mreq, o_busy, o_err;
    logic [AW-1:0] o_maddr;
    logic [DW-1:0] o_irdata;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        instr_req_in  = 1'b0;
        data_req_in   = 1'b0;
        data_we_in    = 1'b0;
        mem_gnt_in    = 1'b0;
        mem_rvalid_in = 1'b0;
        mem_rdata_in  = '0;
    endtask

    // One clock cycle: compare outputs to the model, then advance the model.
    task automatic step();
        bit full, sel_v, sel_o, gnt, hv, ho, ireq, dreq, mg, mrv, locked_req;
        logic          e_we;
        logic [BW-1:0] e_be;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        #1;
        ireq = instr_req_in;
        dreq = data_req_in;
        mg   = mem_gnt_in;
        mrv  = mem_rvalid_in;
        full = (oq.size() == DEPTH);
        locked_req = lock_o ? dreq : ireq;
        sel_v = 1'b0;
        sel_o = 1'b0;
        if (!full) begin
            if (lock_v && locked_req) begin sel_v = 1'b1; sel_o = lock_o; end
            else if (starve == SMAX && ireq) begin sel_v = 1'b1; sel_o = 1'b0; end
            else if (dreq) begin sel_v = 1'b1; sel_o = 1'b1; end
            else if (ireq) begin sel_v = 1'b1; sel_o = 1'b0; end
        end
        gnt = sel_v && mg;
        e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
        if (sel_v && sel_o) begin
            e_we = data_we_in; e_be = data_be_in; e_addr = data_addr_in; e_wd = data_wdata_in;
        end else if (sel_v) begin
            e_be = '1; e_addr = instr_addr_in;
        end
        hv = mrv && (oq.size() > 0);
        ho = hv ? oq[0] : 1'b0;

        check("mem_bus", {mem_req_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out},
                         {sel_v, e_we, e_be, e_addr, e_wd});
        check("grants", {instr_gnt_out, data_gnt_out}, {gnt && !sel_o, gnt && sel_o});
        check("rvalids", {instr_rvalid_out, data_rvalid_out}, {hv && !ho, hv && ho});
        check("rdata", {instr_rdata_out, data_rdata_out}, {mem_rdata_in, mem_rdata_in});
        check("status", {busy_out, err_out}, {oq.size() != 0, err_m});

        m_igt = gnt && !sel_o;  m_dgt = gnt && sel_o;
        o_igt = instr_gnt_out;  o_dgt = data_gnt_out;
        o_irv = instr_rvalid_out; o_drv = data_rvalid_out;
        o_mreq = mem_req_out;   o_maddr = mem_addr_out;
        o_irdata = instr_rdata_out;
        o_busy = busy_out;      o_err = err_out;

        @(posedge clk);
        if (hv) void'(oq.pop_front());
        else if (mrv) err_m = 1'b1;
        if (gnt) oq.push_back(sel_o);
        if (sel_v && !mg) begin lock_v = 1'b1; lock_o = sel_o; end
        else if (gnt) lock_v = 1'b0;
        else if (lock_v && !locked_req) lock_v = 1'b0;
        if (!ireq || (gnt && !sel_o)) starve = 0;
        else if (gnt && sel_o && starve < SMAX) starve++;
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        oq.delete();
        lock_v = 1'b0; lock_o = 1'b0; err_m = 1'b0; starve = 0;
        #1;
        check("rst_state", {mem_req_out, instr_gnt_out, data_gnt_out, instr_rvalid_out,
                            data_rvalid_out, busy_out, err_out, mem_addr_out}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        idle();
        for (int g = 0; g < 8 && oq.size() > 0; g++) begin
            mem_rvalid_in = 1'b1;
            mem_rdata_in  = $urandom;
            step();
        end
        idle();
        check("drained", oq.size(), 0);
    endtask

    initial begin
        bit ipend, dpend;
        lock_v = 1'b0; lock_o = 1'b0; err_m = 1'b0; starve = 0;
        #2;
        check("rst_outs", {mem_req_out, instr_gnt_out, data_gnt_out, instr_rvalid_out,
                           data_rvalid_out, busy_out, err_out}, 7'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Single fetch with zero-latency grant, response next cycle.
        idle(); instr_req_in = 1'b1; instr_addr_in = 32'h100; mem_gnt_in = 1'b1;
        step();
        check("fetch_gnt", o_igt, 1'b1);
        check("fetch_addr", o_maddr, 32'h100);
        check("fetch_busy0", o_busy, 1'b0);
        idle(); mem_rvalid_in = 1'b1; mem_rdata_in = 32'h0010_8093;
        step();
        check("fetch_rv", {o_irv, o_drv}, 2'b10);
        check("fetch_rdata", o_irdata, 32'h0010_8093);
        check("fetch_busy1", o_busy, 1'b1);
        idle(); step();
        check("fetch_busy_end", o_busy, 1'b0);

        // Data priority, fetch forced on the fifth arbitration.
        idle(); data_req_in = 1'b1; data_addr_in = 32'h2000; data_be_in = 4'hF;
        instr_req_in = 1'b1; instr_addr_in = 32'h300; mem_gnt_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_rvalid_in = (oq.size() > 0);
            step();
            check("starve_igt", o_igt, (i == 4));
            check("starve_dgt", o_dgt, (i != 4));
            if (o_igt) instr_req_in = 1'b0;
        end
        drain();

        // Ungranted data request locks the port until granted.
        idle(); data_req_in = 1'b1; data_addr_in = 32'hA0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin instr_req_in = 1'b1; instr_addr_in = 32'h400; end
            step();
            check("lock_addr", o_maddr, 32'hA0);
            check("lock_nognt", {o_igt, o_dgt}, 2'b00);
        end
        mem_gnt_in = 1'b1; step();
        check("lock_dgt", o_dgt, 1'b1);
        data_req_in = 1'b0; step();
        check("lock_rel_igt", o_igt, 1'b1);
        check("lock_rel_addr", o_maddr, 32'h400);
        drain();

        // Full FIFO blocks; in-order responses route to their issuers.
        idle(); data_req_in = 1'b1; data_addr_in = 32'hB0; mem_gnt_in = 1'b1;
        step();
        data_req_in = 1'b0; instr_req_in = 1'b1; instr_addr_in = 32'h500;
        step();
        check("full_igt", o_igt, 1'b1);
        instr_req_in = 1'b0; data_req_in = 1'b1; data_addr_in = 32'hC0;
        step();
        check("full_req", o_mreq, 1'b0);
        mem_rvalid_in = 1'b1; mem_rdata_in = 32'h11;
        step();
        check("full_rv_data", {o_irv, o_drv}, 2'b01);
        check("full_pop_block", o_mreq, 1'b0);
        mem_rdata_in = 32'h22;
        step();
        check("full_rv_instr", {o_irv, o_drv}, 2'b10);
        check("full_resume", o_dgt, 1'b1);
        drain();

        // Stray response sets a sticky error.
        idle(); mem_rvalid_in = 1'b1; step();
        check("err_rv", {o_irv, o_drv}, 2'b00);
        idle(); step();
        check("err_set", o_err, 1'b1);
        step(); step();
        check("err_sticky", o_err, 1'b1);
        do_reset();

        // Reset with outstanding transactions; late response is an error.
        idle(); data_req_in = 1'b1; data_addr_in = 32'hD0; mem_gnt_in = 1'b1;
        step();
        data_req_in = 1'b0; instr_req_in = 1'b1; step();
        idle(); step();
        check("two_busy", o_busy, 1'b1);
        do_reset();
        idle(); mem_rvalid_in = 1'b1; step();
        check("late_rv", {o_irv, o_drv}, 2'b00);
        idle(); step();
        check("late_err", o_err, 1'b1);
        do_reset();

        // Randomized traffic obeying the hold-until-granted protocol.
        ipend = 1'b0; dpend = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!ipend && $urandom_range(0, 2) == 0) begin
                ipend = 1'b1;
                instr_addr_in = $urandom & 32'hFFFF_FFFC;
            end
            if (!dpend && $urandom_range(0, 1) == 0) begin
                dpend = 1'b1;
                data_we_in    = 1'($urandom_range(0, 1));
                data_be_in    = 4'($urandom);
                data_addr_in  = $urandom;
                data_wdata_in = $urandom;
            end
            instr_req_in  = ipend;
            data_req_in   = dpend;
            mem_gnt_in    = ($urandom_range(0, 3) != 0);
            mem_rvalid_in = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_in  = $urandom;
            step();
            if (m_igt) ipend = 1'b0;
            if (m_dgt) dpend = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory req/gnt/rvalid port between the fetch stage (instruction reads) and the load/store path (data reads and writes). Arbitrates each cycle with data priority and a bounded anti-starvation rule for fetch. Holds an arbitration decision stable until granted, and tracks up to DEPTH outstanding transactions so each in-order rvalid is routed back to the requester that issued it. Sits between `fetch` / `execute` and the memory model or bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- DEPTH, 2, max outstanding (granted, not yet rvalid) transactions; ≥1
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; ≥1
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- instr_req_in / instr_addr_in  in  1 / ADDR_W  fetch request (read only)
- instr_gnt_out / instr_rvalid_out  out  1 / 1  fetch grant / response valid
- instr_rdata_out  out  DATA_W  fetch read data
- data_req_in, data_we_in  in  1, 1  data request, write enable
- data_be_in / data_addr_in / data_wdata_in  in  DATA_W/8 / ADDR_W / DATA_W
- data_gnt_out / data_rvalid_out  out  1 / 1
- data_rdata_out  out  DATA_W
- mem_req_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out  out  1, 1, DATA_W/8, ADDR_W, DATA_W
- mem_gnt_in, mem_rvalid_in  in  1, 1; mem_rdata_in  in  DATA_W
- busy_out  out  1  outstanding count ≠ 0
- err_out  out  1  sticky protocol error

## Operation
- Owner select, per cycle, in priority order:
  - lock valid → locked owner
  - starve count == STARVE_MAX and instr_req_in → INSTR
  - data_req_in → DATA
  - instr_req_in → INSTR
  - else none
- Full (count == DEPTH): mem_req_out = 0, both gnt = 0, no owner selected. A pop in the same cycle does not unblock.
- mem_req_out = owner's req & ~full. mem_addr/we/be/wdata come from the owner. For INSTR: we = 0, be = all ones, wdata = 0. With no owner: all mem_* = 0.
- Grant to owner = mem_gnt_in & mem_req_out. The other requester's gnt = 0.
- Lock:
  - Set at clk edge when mem_req_out & ~mem_gnt_in; stores the owner.
  - Cleared on grant.
  - Cleared, without error, if the locked requester drops its req.
- Starve counter:
  - +1 (saturating at STARVE_MAX) on each DATA grant while instr_req_in = 1.
  - Cleared on INSTR grant or when instr_req_in = 0.
- Owner FIFO: each grant pushes the owner id; each mem_rvalid_in pops the head.
  - rvalid goes to the head owner only.
  - mem_rdata_in is passed to both rdata outputs unmodified.
  - Push and pop in the same cycle: count unchanged, order preserved.
- mem_rvalid_in with empty FIFO: no rvalid forwarded, err_out set. err_out stays set until reset.
- Reset asserted: lock, starve count, FIFO and count cleared, err_out = 0. A mem_rvalid_in arriving after reset release for a pre-reset transaction raises err_out. The memory must be reset together with this block.

## Timing
- Reset values: all outputs 0.
- Grant is combinational from mem_gnt_in, same cycle, zero latency. rvalid/rdata are combinational from mem_rvalid_in/mem_rdata_in.
- Requester protocol: hold req and payload stable until gnt.
- Response: earliest the cycle after grant (memory side). Responses are in order.
- Throughput: one grant per cycle while not full. With DEPTH = 1, at most one grant per two cycles.
- FIFO, lock and starve-count updates occur on the rising clk edge. Async clear on reset low.

## Structure
- Package `mem_arb_pkg`:
  - `owner_e` (OWN_INSTR = 1'b0, OWN_DATA = 1'b1)
  - default parameter constants
- Sub-module `owner_fifo`: DEPTH-entry FIFO of `owner_e`.
  - Ports: push, pop, din, dout, full, empty, count.
  - Pointers wrap modulo DEPTH.
- Top level holds the select logic, lock, starve counter and output muxing.

## Test plan
- Single fetch, addr 0x100, mem_gnt_in = 1 same cycle, rvalid 1 cycle later with rdata 0x00108093 → instr_gnt_out = 1 in cycle 0, instr_rvalid_out = 1 with that data in cycle 1, data_rvalid_out = 0, busy_out 1→0.
- Both requesting in the same cycle → data granted first. With data requesting continuously, fetch is granted on the 5th arbitration (STARVE_MAX = 4), then data resumes.
- mem_gnt_in held low 3 cycles while data requests, then instr_req_in rises → mem_addr_out stays the data address until grant, and the lock then releases.
- DEPTH = 2: grants at cycles 0 and 1, no rvalid → cycle 2 mem_req_out = 0. rvalids arrive in order for DATA then INSTR → each routed to its own requester; grants resume after the first pop.
- mem_rvalid_in with nothing outstanding → err_out rises and stays set; neither rvalid_out asserts. Pulse reset → err_out = 0.
- Reset asserted with 2 outstanding → count 0, busy_out = 0 immediately; a late rvalid afterwards sets err_out.
